// File: rtl/vx_alu_dotp_if.sv
// Dispatch/commit bundle of the packed dot-product unit.
// The master modport is the dispatch/commit side, the slave modport is the unit.
interface vx_alu_dotp_if #(
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 8
);
    logic                      valid_in;
    logic                      ready_in;
    logic [1:0]                mode_in;
    logic                      accum_in;
    logic [NUM_LANES-1:0]      tmask_in;
    logic [NUM_LANES*XLEN-1:0] a_in;
    logic [NUM_LANES*XLEN-1:0] b_in;
    logic [NUM_LANES*XLEN-1:0] c_in;
    logic [TAG_WIDTH-1:0]      tag_in;
    logic                      valid_out;
    logic                      ready_out;
    logic [NUM_LANES*XLEN-1:0] data_out;
    logic [NUM_LANES-1:0]      ovf_out;
    logic [TAG_WIDTH-1:0]      tag_out;
    logic                      busy;

    modport master (
        output valid_in, mode_in, accum_in, tmask_in, a_in, b_in, c_in, tag_in, ready_out,
        input  ready_in, valid_out, data_out, ovf_out, tag_out, busy
    );

    modport slave (
        input  valid_in, mode_in, accum_in, tmask_in, a_in, b_in, c_in, tag_in, ready_out,
        output ready_in, valid_out, data_out, ovf_out, tag_out, busy
    );
endinterface

// File: rtl/vx_alu_dotp.sv
// Multi-mode packed-integer dot-product unit (s8x4/u8x4/s4x8/s16x2) with optional
// accumulate and saturation, behind an elastic pipeline with a single global enable.
module vx_alu_dotp #(
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int LATENCY   = 2,
    parameter int TAG_WIDTH = 8,
    parameter int SAT_EN    = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    vx_alu_dotp_if.slave  io
);
    localparam int DW = NUM_LANES * XLEN;

    function automatic logic signed [33:0] sx4(input logic [3:0] v);
        return {{30{v[3]}}, v};
    endfunction

    function automatic logic signed [33:0] sx8(input logic [7:0] v);
        return {{26{v[7]}}, v};
    endfunction

    function automatic logic signed [33:0] zx8(input logic [7:0] v);
        return {26'b0, v};
    endfunction

    function automatic logic signed [33:0] sx16(input logic [15:0] v);
        return {{18{v[15]}}, v};
    endfunction

    function automatic logic signed [33:0] sx32(input logic [31:0] v);
        return {{2{v[31]}}, v};
    endfunction

    logic          en;
    logic          accept;
    logic [DW-1:0] res_data;
    logic [NUM_LANES-1:0] res_ovf;

    // Result is formed combinationally from the dispatch operands, so only
    // finished results (plus tag) need to travel down the pipe.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [31:0]        a;
            logic [31:0]        b;
            logic [31:0]        c;
            logic signed [33:0] sum;
            logic               ovf;
            logic [31:0]        res;
            logic               lane_ovf;

            assign a = io.a_in[gi*XLEN +: 32];
            assign b = io.b_in[gi*XLEN +: 32];
            assign c = io.c_in[gi*XLEN +: 32];

            always_comb begin
                sum = '0;
                case (io.mode_in)
                    2'b00: for (int i = 0; i < 4; i++) sum = sum + sx8(a[8*i +: 8]) * sx8(b[8*i +: 8]);
                    2'b01: for (int i = 0; i < 4; i++) sum = sum + zx8(a[8*i +: 8]) * zx8(b[8*i +: 8]);
                    2'b10: for (int i = 0; i < 8; i++) sum = sum + sx4(a[4*i +: 4]) * sx4(b[4*i +: 4]);
                    default: for (int i = 0; i < 2; i++) sum = sum + sx16(a[16*i +: 16]) * sx16(b[16*i +: 16]);
                endcase
                if (io.accum_in) begin
                    sum = sum + sx32(c);
                end
            end

            // Fits signed 32 only when the top three bits are a pure sign extension.
            assign ovf = (sum[33:31] != 3'b000) && (sum[33:31] != 3'b111);

            always_comb begin
                res      = '0;
                lane_ovf = 1'b0;
                if (io.tmask_in[gi]) begin
                    lane_ovf = ovf;
                    if ((SAT_EN != 0) && ovf) begin
                        res = sum[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    end else begin
                        res = sum[31:0];
                    end
                end
            end

            assign res_data[gi*XLEN +: XLEN] = XLEN'($signed(res));
            assign res_ovf[gi]               = lane_ovf;

            if (XLEN > 32) begin : g_hi
                logic unused_hi;
                assign unused_hi = ^{io.a_in[gi*XLEN+32 +: XLEN-32],
                                     io.b_in[gi*XLEN+32 +: XLEN-32],
                                     io.c_in[gi*XLEN+32 +: XLEN-32]};
            end
        end
    endgenerate

    logic [LATENCY-1:0]   vld_q;
    logic [LATENCY-1:0]   vld_d;
    logic [DW-1:0]        data_q [LATENCY];
    logic [DW-1:0]        data_d [LATENCY];
    logic [NUM_LANES-1:0] ovf_q  [LATENCY];
    logic [NUM_LANES-1:0] ovf_d  [LATENCY];
    logic [TAG_WIDTH-1:0] tag_q  [LATENCY];
    logic [TAG_WIDTH-1:0] tag_d  [LATENCY];

    // One enable for the whole pipe: a stalled head freezes every stage.
    assign en     = ~vld_q[LATENCY-1] | io.ready_out;
    assign accept = io.valid_in & en;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        tag_d  = tag_q;
        if (en) begin
            vld_d[0]  = accept;
            data_d[0] = accept ? res_data  : '0;
            ovf_d[0]  = accept ? res_ovf   : '0;
            tag_d[0]  = accept ? io.tag_in : '0;
            for (int s = 1; s < LATENCY; s++) begin
                vld_d[s]  = vld_q[s-1];
                data_d[s] = data_q[s-1];
                ovf_d[s]  = ovf_q[s-1];
                tag_d[s]  = tag_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
                ovf_q[s]  <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            tag_q  <= tag_d;
        end
    end

    assign io.ready_in  = en;
    assign io.valid_out = vld_q[LATENCY-1];
    assign io.data_out  = data_q[LATENCY-1];
    assign io.ovf_out   = ovf_q[LATENCY-1];
    assign io.tag_out   = tag_q[LATENCY-1];
    assign io.busy      = |vld_q;
endmodule
